rtc_access_sched: RTL and testbench

RTC_ACCESS_SCHED -- requirements
Module: rtc_access_sched

---
 rtl/rtc_access_sched.sv | 180 ++++++++++++++++++
 tb/tb_rtc_access_sched.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_access_sched.sv
// rtc_access_sched: arbitrates RTC shadow-register refresh reads and user writes onto one transfer engine.
// Optional macro RTC_SCHED_TIMEOUT_EN adds a WAIT watchdog with a sticky err output.
`timescale 1ns/1ps
module rtc_access_sched (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       xfer_access,
    output logic       xfer_read,
    input  logic       xfer_done,
    input  logic       avalid,
    input  logic       wvalid,
    input  logic       rvalid,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic [7:0] date,
    output logic [7:0] month,
    output logic [7:0] year,
    output logic       busy,
    output logic       refresh_done
`ifdef RTC_SCHED_TIMEOUT_EN
    ,
    output logic       err
`endif
);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    state_t     state, state_next;
    logic       op_write;
    logic [2:0] idx;
    logic       refresh_pend;
    logic       refresh_active;
    logic       gap_cnt;
    logic [7:0] staging   [6];
    logic [7:0] stage_now [6];
    logic [7:0] slot_addr;
    logic       wr_pending;
    logic       done_read;
    logic       timeout;

`ifdef RTC_SCHED_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       wr_drop;

    assign wr_pending = wr_req && !wr_drop;
    assign timeout    = (state == WAIT) && !xfer_done && (wait_cnt == 8'd254);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'd0;
            wr_drop  <= 1'b0;
            err      <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT && !xfer_done && !timeout) ? wait_cnt + 8'd1 : 8'd0;
            if (timeout)
                err <= 1'b1;
            // A timed-out write is ignored until the user withdraws the request.
            if (timeout && op_write)
                wr_drop <= 1'b1;
            else if (!wr_req)
                wr_drop <= 1'b0;
        end
    end
`else
    assign wr_pending = wr_req;
    assign timeout    = 1'b0;
`endif

    assign slot_addr = 8'h21 + {5'd0, idx};
    assign done_read = (state == WAIT) && xfer_done && !op_write;
    assign busy      = (state != IDLE) || wr_pending || refresh_pend || refresh_active;

    // The byte still on the bus at xfer_done must reach the shadows in the same cycle.
    always_comb begin
        for (int i = 0; i < 6; i++)
            stage_now[i] = (rvalid && idx == 3'(i)) ? bus_in : staging[i];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wr_pending || refresh_pend || refresh_active) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (xfer_done || timeout) state_next = GAP;
            GAP:     if (gap_cnt) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        xfer_access = 1'b0;
        xfer_read   = 1'b0;
        bus_out     = 8'h00;
        bus_oe      = 1'b0;
        wr_ack      = 1'b0;
        case (state)
            START: begin
                xfer_access = 1'b1;
                xfer_read   = !op_write;
            end
            WAIT: begin
                xfer_access = 1'b1;
                xfer_read   = !op_write;
                wr_ack      = op_write && xfer_done;
                if (avalid) begin
                    bus_out = op_write ? wr_addr : slot_addr;
                    bus_oe  = 1'b1;
                end else if (wvalid && op_write) begin
                    bus_out = wr_data;
                    bus_oe  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            op_write       <= 1'b0;
            idx            <= 3'd0;
            refresh_pend   <= 1'b0;
            refresh_active <= 1'b0;
            gap_cnt        <= 1'b0;
            refresh_done   <= 1'b0;
            sec            <= 8'h00;
            min            <= 8'h00;
            hour           <= 8'h00;
            date           <= 8'h00;
            month          <= 8'h00;
            year           <= 8'h00;
            // NOTE: staging is six flops, not a RAM, so it can and must clear on reset.
            for (int i = 0; i < 6; i++)
                staging[i] <= 8'h00;
        end else begin
            state        <= state_next;
            gap_cnt      <= (state == GAP) ? !gap_cnt : 1'b0;
            refresh_done <= 1'b0;
            if (tick)
                refresh_pend <= 1'b1;
            if (state == IDLE && state_next == START)
                op_write <= wr_pending;
            // Starting a fresh sequence consumes the pending tick; later ticks queue one more.
            if (state == START && !op_write && !refresh_active) begin
                refresh_active <= 1'b1;
                refresh_pend   <= tick;
            end
            if (state == WAIT && !op_write && rvalid)
                staging[idx] <= bus_in;
            if (done_read) begin
                if (idx == 3'd5) begin
                    sec            <= stage_now[0];
                    min            <= stage_now[1];
                    hour           <= stage_now[2];
                    date           <= stage_now[3];
                    month          <= stage_now[4];
                    year           <= stage_now[5];
                    refresh_done   <= 1'b1;
                    refresh_active <= 1'b0;
                    idx            <= 3'd0;
                end else begin
                    idx <= idx + 3'd1;
                end
            end
            if (timeout && !op_write)
                idx <= 3'd0;
        end
    end

endmodule

// File: tb/tb_rtc_access_sched.sv
// Bench for rtc_access_sched: randomized engine timing and RTC contents, checked by an
// expected-transfer scoreboard and a shadow-register model.
`timescale 1ns/1ps
module tb_rtc_access_sched;

    logic       clk = 1'b0;
    logic       reset, tick, wr_req;
    logic [7:0] wr_addr, wr_data;
    logic       wr_ack, xfer_access, xfer_read;
    logic       xfer_done, avalid, wvalid, rvalid;
    logic [7:0] bus_out, bus_in;
    logic       bus_oe;
    logic [7:0] sec, min, hour, date, month, year;
    logic       busy, refresh_done;
`ifdef RTC_SCHED_TIMEOUT_EN
    logic       err;
    bit         withhold_done;
`endif

    typedef struct {
        bit         rd;
        logic [7:0] addr;
        logic [7:0] data;
    } xact_t;

    xact_t       exp_q[$];
    logic [47:0] shadow_q[$];
    logic [7:0]  mem [256];
    int          n_checks, n_errors;
    int          ack_seen, ack_exp, done_seen, done_exp;
    logic [7:0]  eng_addr;
    bit          eng_active;

    rtc_access_sched dut (
        .clk(clk), .reset(reset), .tick(tick),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .xfer_access(xfer_access), .xfer_read(xfer_read), .xfer_done(xfer_done),
        .avalid(avalid), .wvalid(wvalid), .rvalid(rvalid),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
        .sec(sec), .min(min), .hour(hour), .date(date), .month(month), .year(year),
        .busy(busy), .refresh_done(refresh_done)
`ifdef RTC_SCHED_TIMEOUT_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s", name);
    endtask

    // ---------------- transfer engine model (also the transfer monitor) ----------------
    task automatic step(output bit aborted);
        @(posedge clk);
        #1;
        aborted = reset;
    endtask

    task automatic eng_clear();
        avalid     = 1'b0;
        wvalid     = 1'b0;
        rvalid     = 1'b0;
        xfer_done  = 1'b0;
        eng_active = 1'b0;
    endtask

    task automatic run_transfer();
        xact_t      e;
        bit         rd, ab;
        logic [7:0] a;
        int         n;
        rd = xfer_read;
        eng_active = 1'b1;
        e = '{rd: 1'b0, addr: 8'h00, data: 8'h00};
        a = 8'h00;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            step(ab);
            if (ab) begin eng_clear(); return; end
        end
        avalid = 1'b1;
        n = $urandom_range(1, 2);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                a = bus_out;
                eng_addr = a;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_transfer");
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_read", 64'(rd), 64'(e.rd));
                    check("bus_addr", 64'(a), 64'(e.addr));
                end
            end else begin
                check("bus_addr_hold", 64'(bus_out), 64'(a));
            end
            check("bus_oe_addr", 64'(bus_oe), 64'(1));
            step(ab);
            if (ab) begin eng_clear(); return; end
        end
        avalid = 1'b0;
        if (rd) begin
            n = $urandom_range(1, 2);
            rvalid = 1'b1;
            for (int i = 0; i < n; i++) begin
                bus_in = (i == n - 1) ? mem[a] : 8'($urandom);
                @(negedge clk);
                check("bus_oe_read", 64'(bus_oe), 64'(0));
                step(ab);
                if (ab) begin eng_clear(); return; end
            end
            rvalid = 1'b0;
        end else begin
            wvalid = 1'b1;
            @(negedge clk);
            check("bus_oe_wdata", 64'(bus_oe), 64'(1));
            check("bus_wdata", 64'(bus_out), 64'(e.data));
            step(ab);
            if (ab) begin eng_clear(); return; end
            wvalid = 1'b0;
        end
`ifdef RTC_SCHED_TIMEOUT_EN
        if (withhold_done) begin
            for (int i = 0; i < 400 && xfer_access; i++) begin
                step(ab);
                if (ab) begin eng_clear(); return; end
            end
            check("timeout_abort", 64'(xfer_access), 64'(0));
            eng_clear();
            return;
        end
`endif
        xfer_done = 1'b1;
        @(negedge clk);
        check("done_access", 64'(xfer_access), 64'(1));
        check("done_read_stable", 64'(xfer_read), 64'(rd));
        check("wr_ack_on_done", 64'(wr_ack), 64'(!rd));
        step(ab);
        eng_clear();
    endtask

    initial begin : engine
        int gap;
        bit have_prev;
        gap = 0;
        have_prev = 1'b0;
        bus_in = 8'h00;
        eng_addr = 8'h00;
        eng_clear();
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                have_prev = 1'b0;
                gap = 0;
            end else if (!xfer_access) begin
                gap++;
            end else begin
                if (have_prev)
                    check("xfer_gap_ge2", 64'(gap >= 2), 64'(1));
                run_transfer();
                have_prev = !reset;
                gap = 0;
            end
        end
    end

    // ---------------- shadow monitor ----------------
    initial begin : monitor
        logic [47:0] model, cur;
        model = 48'h0;
        forever begin
            @(negedge clk);
            cur = {sec, min, hour, date, month, year};
            if (reset) begin
                model = 48'h0;
            end else begin
                if (wr_ack)
                    ack_seen++;
                if (refresh_done) begin
                    done_seen++;
                    if (shadow_q.size() == 0)
                        fail_now("unexpected_refresh_done");
                    else
                        model = shadow_q.pop_front();
                end
                check("shadows", 64'(cur), 64'(model));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_reads(input int count);
        for (int i = 0; i < count; i++)
            exp_q.push_back('{rd: 1'b1, addr: 8'(8'h21 + i % 6), data: 8'h00});
    endtask

    task automatic push_shadow();
        shadow_q.push_back({mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24], mem[8'h25], mem[8'h26]});
        done_exp++;
    endtask

    task automatic randomize_mem();
        for (int a = 8'h21; a <= 8'h26; a++)
            mem[a] = 8'($urandom);
    endtask

    task automatic pulse_tick();
        @(posedge clk); #1; tick = 1'b1;
        @(posedge clk); #1; tick = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        bit acked;
        @(posedge clk); #1;
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        acked   = 1'b0;
        for (int i = 0; i < 2000 && !acked; i++) begin
            @(negedge clk);
            acked = wr_ack;
        end
        if (!acked)
            fail_now("wr_ack_timeout");
        @(posedge clk); #1;
        wr_req = 1'b0;
    endtask

    task automatic wait_xfer(input logic [7:0] a);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk); #1;
            ok = eng_active && eng_addr == a;
        end
        if (!ok)
            fail_now("wait_xfer_timeout");
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            ok = !busy && !eng_active && exp_q.size() == 0 && shadow_q.size() == 0;
        end
        if (!ok) begin
            $display("FAIL wait_idle_timeout: %0d transfers and %0d refreshes outstanding",
                     exp_q.size(), shadow_q.size());
            n_checks++;
            n_errors++;
            exp_q.delete();
            shadow_q.delete();
        end
    endtask

    initial begin : stim
        logic [7:0] a, d;
        reset = 1'b1; tick = 1'b0; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
`ifdef RTC_SCHED_TIMEOUT_EN
        withhold_done = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_xfer_access", 64'(xfer_access), 64'(0));
        check("rst_xfer_read", 64'(xfer_read), 64'(0));
        check("rst_bus", 64'({bus_oe, bus_out}), 64'(0));
        check("rst_pulses", 64'({wr_ack, refresh_done}), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_shadows", 64'({sec, min, hour, date, month, year}), 64'(0));
        reset = 1'b0;

        // Directed refresh with known RTC contents.
        mem[8'h21] = 8'h30; mem[8'h22] = 8'h15; mem[8'h23] = 8'h09;
        mem[8'h24] = 8'h24; mem[8'h25] = 8'h06; mem[8'h26] = 8'h25;
        push_reads(6);
        push_shadow();
        pulse_tick();
        @(negedge clk);
        check("busy_pending", 64'(busy), 64'(1));
        wait_idle(2000);

        // Directed user write while idle.
        exp_q.push_back('{rd: 1'b0, addr: 8'h22, data: 8'h45});
        ack_exp++;
        do_write(8'h22, 8'h45);
        wait_idle(500);

        // Write raised during slot 2 runs between slots 2 and 3.
        randomize_mem();
        push_reads(3);
        pulse_tick();
        wait_xfer(8'h23);
        exp_q.push_back('{rd: 1'b0, addr: 8'h5a, data: 8'hc3});
        for (int i = 3; i < 6; i++)
            exp_q.push_back('{rd: 1'b1, addr: 8'(8'h21 + i), data: 8'h00});
        push_shadow();
        ack_exp++;
        do_write(8'h5a, 8'hc3);
        wait_idle(2000);

        // Three ticks during one refresh merge into exactly one more refresh.
        randomize_mem();
        push_reads(12);
        push_shadow();
        push_shadow();
        pulse_tick();
        wait_xfer(8'h23);
        repeat (3) begin
            pulse_tick();
            repeat (2) @(posedge clk);
        end
        wait_idle(4000);

        // Reset in WAIT of slot 4 drops access without a clock edge.
        randomize_mem();
        push_reads(6);
        pulse_tick();
        wait_xfer(8'h25);
        #2 reset = 1'b1;
        #1;
        check("async_rst_access", 64'(xfer_access), 64'(0));
        check("async_rst_oe", 64'(bus_oe), 64'(0));
        check("async_rst_shadows", 64'({sec, min, hour, date, month, year}), 64'(0));
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_quiet", 64'({busy, xfer_access}), 64'(0));

        // Randomized mix of refreshes and writes.
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                randomize_mem();
                push_reads(6);
                push_shadow();
                pulse_tick();
                wait_idle(2000);
            end else begin
                a = 8'($urandom);
                d = 8'($urandom);
                exp_q.push_back('{rd: 1'b0, addr: a, data: d});
                ack_exp++;
                do_write(a, d);
                wait_idle(500);
            end
        end

`ifdef RTC_SCHED_TIMEOUT_EN
        check("err_idle", 64'(err), 64'(0));
        randomize_mem();
        push_reads(1);
        withhold_done = 1'b1;
        pulse_tick();
        for (int i = 0; i < 1000 && !err; i++)
            @(negedge clk);
        check("err_set", 64'(err), 64'(1));
        withhold_done = 1'b0;
        push_reads(6);
        push_shadow();
        wait_idle(3000);
        check("err_sticky", 64'(err), 64'(1));
`endif

        repeat (5) @(negedge clk);
        check("wr_ack_count", 64'(ack_seen), 64'(ack_exp));
        check("refresh_done_count", 64'(done_seen), 64'(done_exp));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
